// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU control decoder
// and the seq_alu datapath, plus the seq_alu FSM state encoding.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND   = 4'b0000;
    localparam alu_op_t ALU_OR    = 4'b0001;
    localparam alu_op_t ALU_ADD   = 4'b0010;
    localparam alu_op_t ALU_EQUAL = 4'b0011;
    localparam alu_op_t ALU_SLL   = 4'b0100;
    localparam alu_op_t ALU_SRL   = 4'b0101;
    localparam alu_op_t ALU_SRA   = 4'b0111;
    localparam alu_op_t ALU_XOR   = 4'b1000;
    localparam alu_op_t ALU_NOR   = 4'b1001;
    localparam alu_op_t ALU_SUB   = 4'b1010;
    localparam alu_op_t ALU_GE    = 4'b1100;
    localparam alu_op_t ALU_GEU   = 4'b1101;
    localparam alu_op_t ALU_SLT   = 4'b1110;
    localparam alu_op_t ALU_SLTU  = 4'b1111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_core.sv
// Single-cycle combinational ALU datapath for seq_alu.
// Ports: alu_op_i (op code), op_a_i/op_b_i (operands), result_o (result).
// Shift ops are only computed here when SEQ_ALU_BARREL_SHIFT_EN is defined;
// otherwise they return 0 and the top-level iterative shifter handles them.
module seq_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o
);

    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] one;

    assign eq   = (op_a_i == op_b_i);
    assign lt_s = ($signed(op_a_i) < $signed(op_b_i));
    assign lt_u = (op_a_i < op_b_i);
    assign one  = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef SEQ_ALU_BARREL_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = op_b_i[4:0];
`endif

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_AND:   result_o = op_a_i & op_b_i;
            ALU_OR:    result_o = op_a_i | op_b_i;
            ALU_ADD:   result_o = op_a_i + op_b_i;
            ALU_EQUAL: result_o = eq ? one : '0;
            ALU_XOR:   result_o = op_a_i ^ op_b_i;
            ALU_NOR:   result_o = ~(op_a_i | op_b_i);
            ALU_SUB:   result_o = op_a_i - op_b_i;
            ALU_GE:    result_o = lt_s ? '0 : one;
            ALU_GEU:   result_o = lt_u ? '0 : one;
            ALU_SLT:   result_o = lt_s ? one : '0;
            ALU_SLTU:  result_o = lt_u ? one : '0;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
            ALU_SLL:   result_o = op_a_i << shamt;
            ALU_SRL:   result_o = op_a_i >> shamt;
            ALU_SRA:   result_o = $unsigned($signed(op_a_i) >>> shamt);
`endif
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU with valid/ready input and one-cycle result strobe.
// Ports: clk_i, rst_i (sync, active-high), valid_i/ready_o (request
// handshake), alu_op_i, op_a_i, op_b_i (operation), result_valid_o
// (strobe), result_o (held result), zero_o (result_o == 0).
// Macro SEQ_ALU_BARREL_SHIFT_EN: single-cycle shifts, no shift register.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       alu_op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    logic [1:0]       state;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] core_result;

    seq_alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .alu_op_i(alu_op_i),
        .op_a_i  (op_a_i),
        .op_b_i  (op_b_i),
        .result_o(core_result)
    );

    assign ready_o        = (state == ST_IDLE);
    assign result_valid_o = (state == ST_DONE);
    assign result_o       = result_q;
    assign zero_o         = (result_q == '0);

`ifdef SEQ_ALU_BARREL_SHIFT_EN

    // Every op, shifts included, completes in the acceptance cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        result_q <= core_result;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`else

    logic [WIDTH-1:0] shreg;
    logic [4:0]       count;
    logic [3:0]       op_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            result_q <= '0;
            shreg    <= '0;
            count    <= '0;
            op_q     <= ALU_AND;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (is_shift(alu_op_i)) begin
                            shreg <= op_a_i;
                            count <= op_b_i[4:0];
                            op_q  <= alu_op_i;
                            state <= ST_SHIFT;
                        end else begin
                            result_q <= core_result;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    // One bit per cycle; count==0 publishes the result.
                    if (count == 5'd0) begin
                        result_q <= shreg;
                        state    <= ST_DONE;
                    end else begin
                        count <= count - 5'd1;
                        unique case (1'b1)
                            op_q == ALU_SLL:
                                shreg <= {shreg[WIDTH-2:0], 1'b0};
                            op_q == ALU_SRL:
                                shreg <= {1'b0, shreg[WIDTH-1:1]};
                            default:
                                shreg <= {shreg[WIDTH-1], shreg[WIDTH-1:1]};
                        endcase
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`endif

endmodule
